// File: rtl/decoder_addr_sequencer.sv
// ============================================================================
// Module  : decoder_addr_sequencer
// Brief   : Sweeps the 2-bit select of a 2-to-4 decoder up or down, holding
//           each code DWELL clocks, with single/continuous and graceful stop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decoder_addr_sequencer #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               dir,
  input  logic               single,
  output logic               a1,
  output logic               a0,
  output logic               en,
  output logic               step,
  output logic               sweep_done,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [DWELL_W-1:0] C_LAST = DWELL_W'(DWELL - 1);

  state_t               r_state;
  logic [1:0]           r_code;
  logic [DWELL_W-1:0]   r_dwell;
  logic                 r_dir;
  logic                 r_single;
  logic                 r_stop_pend;
  logic                 r_step;
  logic                 r_sweep_done;
  logic [SWEEP_W-1:0]   r_sweep_cnt;

  state_t               w_state_nxt;
  logic [1:0]           w_code_nxt;
  logic [DWELL_W-1:0]   w_dwell_nxt;
  logic                 w_dir_nxt;
  logic                 w_single_nxt;
  logic                 w_at_step;
  logic                 w_at_final;
  logic                 w_stopping;
  logic                 w_step_nxt;
  logic                 w_done_nxt;

  assign w_at_step  = (r_state == SCAN) && (r_dwell == C_LAST);
  assign w_at_final = (r_code == (r_dir ? 2'd0 : 2'd3));
  // A stop seen on the step edge itself still lets the current dwell finish.
  assign w_stopping = r_stop_pend | stop;

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_dwell_nxt  = r_dwell;
    w_dir_nxt    = r_dir;
    w_single_nxt = r_single;
    case (r_state)
      IDLE: begin
        if (start && !stop) begin
          w_state_nxt  = SCAN;
          w_dir_nxt    = dir;
          w_single_nxt = single;
          w_code_nxt   = dir ? 2'd3 : 2'd0;
          w_dwell_nxt  = '0;
        end
      end
      SCAN: begin
        if (w_at_step) begin
          w_dwell_nxt = '0;
          if (w_at_final) begin
            if (r_single || w_stopping) w_state_nxt = IDLE;
            else                        w_code_nxt  = r_dir ? 2'd3 : 2'd0;
          end else if (w_stopping) begin
            w_state_nxt = IDLE;
          end else begin
            w_code_nxt = r_dir ? (r_code - 2'd1) : (r_code + 2'd1);
          end
        end else begin
          w_dwell_nxt = r_dwell + DWELL_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Step and sweep_done are computed one edge early so they are plain flops.
  assign w_step_nxt = (w_state_nxt == SCAN) && (w_dwell_nxt == C_LAST);
  assign w_done_nxt = w_step_nxt && (w_code_nxt == (w_dir_nxt ? 2'd0 : 2'd3));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_code       <= 2'd0;
      r_dwell      <= '0;
      r_dir        <= 1'b0;
      r_single     <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_step       <= 1'b0;
      r_sweep_done <= 1'b0;
      r_sweep_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_code       <= w_code_nxt;
      r_dwell      <= w_dwell_nxt;
      r_dir        <= w_dir_nxt;
      r_single     <= w_single_nxt;
      r_step       <= w_step_nxt;
      r_sweep_done <= w_done_nxt;
      if (w_at_step && w_at_final)
        r_sweep_cnt <= r_sweep_cnt + SWEEP_W'(1);
      if (w_state_nxt == IDLE)
        r_stop_pend <= 1'b0;
      else if (r_state == SCAN && stop)
        r_stop_pend <= 1'b1;
    end
  end

  assign a1         = r_code[1];
  assign a0         = r_code[0];
  assign en         = (r_state == SCAN);
  assign busy       = (r_state != IDLE);
  assign step       = r_step;
  assign sweep_done = r_sweep_done;
  assign sweep_cnt  = r_sweep_cnt;

endmodule

`default_nettype wire

// File: tb/tb_decoder_addr_sequencer.sv
// ============================================================================
// Module  : tb_decoder_addr_sequencer
// Brief   : Randomized self-checking bench for three parameterizations of
//           decoder_addr_sequencer against a sweep-time reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decoder_addr_sequencer;

  localparam int N_INST = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, dir, single;

  always #5 clk = ~clk;

  logic       a1_0, a0_0, en_0, step_0, sd_0, busy_0;
  logic [7:0] cnt_0;
  logic       a1_1, a0_1, en_1, step_1, sd_1, busy_1;
  logic [1:0] cnt_1;
  logic       a1_2, a0_2, en_2, step_2, sd_2, busy_2;
  logic [1:0] cnt_2;

  decoder_addr_sequencer #(.DWELL(4), .DWELL_W(8), .SWEEP_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .single(single),
    .a1(a1_0), .a0(a0_0), .en(en_0), .step(step_0), .sweep_done(sd_0),
    .sweep_cnt(cnt_0), .busy(busy_0)
  );

  decoder_addr_sequencer #(.DWELL(1), .DWELL_W(8), .SWEEP_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .single(single),
    .a1(a1_1), .a0(a0_1), .en(en_1), .step(step_1), .sweep_done(sd_1),
    .sweep_cnt(cnt_1), .busy(busy_1)
  );

  decoder_addr_sequencer #(.DWELL(3), .DWELL_W(2), .SWEEP_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .single(single),
    .a1(a1_2), .a0(a0_2), .en(en_2), .step(step_2), .sweep_done(sd_2),
    .sweep_cnt(cnt_2), .busy(busy_2)
  );

  // Observed word: {2'b0, a1, a0, en, step, sweep_done, busy, cnt[7:0]}
  logic [15:0] obs [N_INST];
  assign obs[0] = {2'b00, a1_0, a0_0, en_0, step_0, sd_0, busy_0, cnt_0};
  assign obs[1] = {2'b00, a1_1, a0_1, en_1, step_1, sd_1, busy_1, 6'd0, cnt_1};
  assign obs[2] = {2'b00, a1_2, a0_2, en_2, step_2, sd_2, busy_2, 6'd0, cnt_2};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sweep is a timeline t = 0 .. 4*DWELL-1; code, step and
  // sweep_done are read straight off that timeline.
  int dw   [N_INST] = '{4, 1, 3};
  int cmod [N_INST] = '{256, 4, 4};
  bit m_scan   [N_INST];
  int m_t      [N_INST];
  bit m_dir    [N_INST];
  bit m_single [N_INST];
  bit m_pend   [N_INST];
  int m_held   [N_INST];
  int m_cnt    [N_INST];

  function automatic int m_code(int i);
    if (!m_scan[i]) return m_held[i];
    return m_dir[i] ? 3 - m_t[i] / dw[i] : m_t[i] / dw[i];
  endfunction

  function automatic logic [15:0] m_out(int i);
    bit s, d;
    logic [1:0] c;
    s = m_scan[i] && (m_t[i] % dw[i] == dw[i] - 1);
    d = m_scan[i] && (m_t[i] == 4 * dw[i] - 1);
    c = 2'(m_code(i));
    return {2'b00, c, m_scan[i], s, d, m_scan[i], 8'(m_cnt[i])};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_INST; i++) begin
      m_scan[i] = 0; m_t[i] = 0; m_dir[i] = 0; m_single[i] = 0;
      m_pend[i] = 0; m_held[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic m_edge(int i);
    bit stopping;
    if (m_scan[i]) begin
      if (m_t[i] % dw[i] == dw[i] - 1) begin
        stopping = m_pend[i] || stop;
        if (m_t[i] == 4 * dw[i] - 1) begin
          m_cnt[i] = (m_cnt[i] + 1) % cmod[i];
          if (m_single[i] || stopping) begin
            m_held[i] = m_code(i); m_scan[i] = 0; m_pend[i] = 0;
          end else begin
            m_t[i] = 0;
          end
        end else if (stopping) begin
          m_held[i] = m_code(i); m_scan[i] = 0; m_pend[i] = 0;
        end else begin
          m_t[i]++;
        end
      end else begin
        m_t[i]++;
        if (stop) m_pend[i] = 1;
      end
    end else if (start && !stop) begin
      m_scan[i] = 1; m_t[i] = 0; m_pend[i] = 0;
      m_dir[i] = dir; m_single[i] = single;
    end
  endtask

  task automatic compare_all(string what);
    for (int i = 0; i < N_INST; i++)
      check($sformatf("%s_inst%0d", what, i), obs[i], m_out(i));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N_INST; i++) m_edge(i);
    #1;
    compare_all("model");
  endtask

  // Reset lands mid-cycle to show it acts without waiting for a clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    compare_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; dir = 0; single = 0;
    m_reset();
    @(posedge clk); #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed continuous-up sweep on the DWELL=4 instance
    start = 1; dir = 0; single = 0;
    tick();
    start = 0;
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("dir_code_c%0d", k), {14'd0, a1_0, a0_0}, 16'(((k - 1) / 4) % 4));
      check($sformatf("dir_step_c%0d", k), {15'd0, step_0}, 16'(k % 4 == 0));
      check($sformatf("dir_done_c%0d", k), {15'd0, sd_0}, 16'(k == 16));
      check($sformatf("dir_cnt_c%0d", k), {8'd0, cnt_0}, 16'(k >= 17));
      tick();
    end

    // Randomized phase with occasional asynchronous resets
    for (int n = 0; n < 4000; n++) begin
      start  = ($urandom % 6) == 0;
      stop   = ($urandom % 18) == 0;
      dir    = $urandom % 2;
      single = ($urandom % 3) == 0;
      tick();
      if (($urandom % 800) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
